adma_as_atx_dispatch: RTL and testbench



---
 rtl/adma_pkg.sv | 26 ++
 rtl/adma_sync_fifo.sv | 55 +++++
 rtl/adma_as_atx_dispatch.sv | 144 ++++++++++++++
 tb/tb_adma_as_atx_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_pkg.sv
// Shared AXI DMA types and constants used by the dispatch stage and its helpers.
package adma_pkg;

  localparam logic [1:0] BURST_FIX  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int DEF_SRC_ADDR_W = 32;
  localparam int DEF_DST_ADDR_W = 32;
  localparam int DEF_MST_ID_W   = 5;
  localparam int DEF_ATX_LEN_W  = 8;

  // One split AXI transaction at the default datapath widths.
  typedef struct packed {
    logic [DEF_MST_ID_W-1:0]   arid;
    logic [DEF_SRC_ADDR_W-1:0] araddr;
    logic [DEF_ATX_LEN_W-1:0]  arlen;
    logic [1:0]                arburst;
    logic [DEF_MST_ID_W-1:0]   awid;
    logic [DEF_DST_ADDR_W-1:0] awaddr;
    logic [DEF_ATX_LEN_W-1:0]  awlen;
    logic [1:0]                awburst;
    logic                      last;
  } atx_info_t;

endpackage

// File: rtl/adma_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module adma_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adma_as_atx_dispatch.sv
// Issues AR/AW address phases of split AXI transactions and tracks write
// completions, flagging the B response that ends each DMA transaction.
module adma_as_atx_dispatch
  import adma_pkg::*;
#(
  parameter int SRC_ADDR_W = 32,
  parameter int DST_ADDR_W = 32,
  parameter int MST_ID_W   = 5,
  parameter int ATX_LEN_W  = 8,
  parameter int OUTST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MST_ID_W-1:0]           arid,
  input  logic [SRC_ADDR_W-1:0]         araddr,
  input  logic [ATX_LEN_W-1:0]          arlen,
  input  logic [1:0]                    arburst,
  input  logic [MST_ID_W-1:0]           awid,
  input  logic [DST_ADDR_W-1:0]         awaddr,
  input  logic [ATX_LEN_W-1:0]          awlen,
  input  logic [1:0]                    awburst,
  input  logic                          atx_last,
  input  logic                          atx_vld,
  output logic                          atx_rdy,
  output logic [MST_ID_W-1:0]           m_arid,
  output logic [SRC_ADDR_W-1:0]         m_araddr,
  output logic [ATX_LEN_W-1:0]          m_arlen,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [MST_ID_W-1:0]           m_awid,
  output logic [DST_ADDR_W-1:0]         m_awaddr,
  output logic [ATX_LEN_W-1:0]          m_awlen,
  output logic [1:0]                    m_awburst,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  input  logic [MST_ID_W-1:0]           m_bid,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic                          tx_done,
  output logic                          tx_err,
  input  logic                          err_clr,
  output logic [$clog2(OUTST_MAX):0]    outst_cnt
);

  typedef struct packed {
    logic [MST_ID_W-1:0]   id;
    logic [SRC_ADDR_W-1:0] addr;
    logic [ATX_LEN_W-1:0]  len;
    logic [1:0]            burst;
  } ar_pl_t;

  typedef struct packed {
    logic [MST_ID_W-1:0]   id;
    logic [DST_ADDR_W-1:0] addr;
    logic [ATX_LEN_W-1:0]  len;
    logic [1:0]            burst;
  } aw_pl_t;

  ar_pl_t              ar_pl;
  aw_pl_t              aw_pl;
  logic                ar_pend;
  logic                aw_pend;
  logic                ar_hs;
  logic                aw_hs;
  logic                b_hs;
  logic                accept;
  logic                b_err;
  logic                trk_full;
  logic                trk_empty;
  logic [MST_ID_W:0]   trk_head;
  logic [MST_ID_W-1:0] head_id;
  logic                head_last;

  assign ar_hs   = ar_pend & m_arready;
  assign aw_hs   = aw_pend & m_awready;
  // trk_full is registered: a B popping this cycle cannot make room for this cycle's accept.
  assign atx_rdy = (~ar_pend | ar_hs) & (~aw_pend | aw_hs) & ~trk_full;
  assign accept  = atx_vld & atx_rdy;

  assign m_bready = ~trk_empty;
  assign b_hs     = m_bvalid & m_bready;
  assign {head_id, head_last} = trk_head;
  assign b_err    = b_hs & ((m_bresp != RESP_OKAY) | (m_bid != head_id));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_pend <= 1'b0;
      aw_pend <= 1'b0;
      ar_pl   <= '0;
      aw_pl   <= '0;
    end else begin
      ar_pend <= accept | (ar_pend & ~ar_hs);
      aw_pend <= accept | (aw_pend & ~aw_hs);
      if (accept) begin
        ar_pl <= '{id: arid, addr: araddr, len: arlen, burst: arburst};
        aw_pl <= '{id: awid, addr: awaddr, len: awlen, burst: awburst};
      end
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      tx_done <= b_hs & head_last;
      if (b_err)        tx_err <= 1'b1;
      else if (err_clr) tx_err <= 1'b0;
    end
  end

  adma_sync_fifo #(
    .WIDTH (MST_ID_W + 1),
    .DEPTH (OUTST_MAX)
  ) u_trk_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({awid, atx_last}),
    .pop       (b_hs),
    .pop_data  (trk_head),
    .full      (trk_full),
    .empty     (trk_empty),
    .count     (outst_cnt)
  );

  assign m_arvalid = ar_pend;
  assign m_arid    = ar_pl.id;
  assign m_araddr  = ar_pl.addr;
  assign m_arlen   = ar_pl.len;
  assign m_arburst = ar_pl.burst;

  assign m_awvalid = aw_pend;
  assign m_awid    = aw_pl.id;
  assign m_awaddr  = aw_pl.addr;
  assign m_awlen   = aw_pl.len;
  assign m_awburst = aw_pl.burst;

endmodule

// File: tb/tb_adma_as_atx_dispatch.sv
// Scoreboard bench for adma_as_atx_dispatch: drivers queue expected AR/AW
// payloads and B-completion flags, a negedge monitor compares them.
module tb_adma_as_atx_dispatch;
  import adma_pkg::*;

  localparam int SRC_ADDR_W = 32;
  localparam int DST_ADDR_W = 32;
  localparam int MST_ID_W   = 5;
  localparam int ATX_LEN_W  = 8;
  localparam int OUTST_MAX  = 4;
  localparam int TMO        = 50;

  logic clk, rst_n;
  logic [MST_ID_W-1:0] arid, awid, m_arid, m_awid, m_bid;
  logic [SRC_ADDR_W-1:0] araddr, m_araddr;
  logic [DST_ADDR_W-1:0] awaddr, m_awaddr;
  logic [ATX_LEN_W-1:0] arlen, awlen, m_arlen, m_awlen;
  logic [1:0] arburst, awburst, m_arburst, m_awburst, m_bresp;
  logic atx_last, atx_vld, atx_rdy;
  logic m_arvalid, m_arready, m_awvalid, m_awready;
  logic m_bvalid, m_bready, tx_done, tx_err, err_clr;
  logic [$clog2(OUTST_MAX):0] outst_cnt;

  adma_as_atx_dispatch #(
    .SRC_ADDR_W(SRC_ADDR_W), .DST_ADDR_W(DST_ADDR_W), .MST_ID_W(MST_ID_W),
    .ATX_LEN_W(ATX_LEN_W), .OUTST_MAX(OUTST_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .atx_last(atx_last), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .tx_done(tx_done), .tx_err(tx_err), .err_clr(err_clr), .outst_cnt(outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] ar_exp_q[$];
  logic [63:0] aw_exp_q[$];
  logic        b_exp_q[$];
  bit          b_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_pl(input logic [MST_ID_W-1:0] id,
                                          input logic [31:0] addr,
                                          input logic [ATX_LEN_W-1:0] len,
                                          input logic [1:0] burst);
    return 64'({id, addr, len, burst});
  endfunction

  // Monitor: payload must match the queue head on every cycle valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      b_seen = 1'b0;
    end else begin
      if (m_arvalid) begin
        if (ar_exp_q.size() == 0) check("ar_unexpected", m_arvalid, 0);
        else begin
          check("ar_payload", pack_pl(m_arid, m_araddr, m_arlen, m_arburst), ar_exp_q[0]);
          if (m_arready) void'(ar_exp_q.pop_front());
        end
      end
      if (m_awvalid) begin
        if (aw_exp_q.size() == 0) check("aw_unexpected", m_awvalid, 0);
        else begin
          check("aw_payload", pack_pl(m_awid, m_awaddr, m_awlen, m_awburst), aw_exp_q[0]);
          if (m_awready) void'(aw_exp_q.pop_front());
        end
      end
      if (b_seen) begin
        if (b_exp_q.size() == 0) check("b_unexpected", b_seen, 0);
        else check("tx_done", tx_done, b_exp_q.pop_front());
        b_seen = 1'b0;
      end else begin
        check("tx_done_idle", tx_done, 0);
      end
      if (m_bvalid && m_bready) b_seen = 1'b1;
    end
  end

  // Drives one transaction; returns one step after the accepting edge with atx_vld still high.
  task automatic send_atx(input logic [MST_ID_W-1:0] id, input logic [31:0] ra,
                          input logic [31:0] wa, input logic [7:0] len,
                          input logic last, output int waits);
    arid = id; awid = id; araddr = ra; awaddr = wa; arlen = len; awlen = len;
    arburst = BURST_INCR; awburst = BURST_INCR; atx_last = last; atx_vld = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!atx_rdy && waits < TMO) begin
      waits++;
      @(negedge clk);
    end
    if (!atx_rdy) check("atx_timeout", atx_rdy, 1);
    else begin
      ar_exp_q.push_back(pack_pl(id, ra, len, BURST_INCR));
      aw_exp_q.push_back(pack_pl(id, wa, len, BURST_INCR));
    end
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [MST_ID_W-1:0] id, input logic [1:0] resp, input logic exp_done);
    int w = 0;
    m_bid = id; m_bresp = resp; m_bvalid = 1'b1;
    @(negedge clk);
    while (!m_bready && w < TMO) begin
      w++;
      @(negedge clk);
    end
    if (!m_bready) check("b_timeout", m_bready, 1);
    else b_exp_q.push_back(exp_done);
    @(posedge clk); #1;
    m_bvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_awvalid"}, m_awvalid, 0);
    check({tag, "_bready"}, m_bready, 0);
    check({tag, "_tx_done"}, tx_done, 0);
    check({tag, "_tx_err"}, tx_err, 0);
    check({tag, "_outst"}, outst_cnt, 0);
    check({tag, "_ar_pl"}, pack_pl(m_arid, m_araddr, m_arlen, m_arburst), 0);
    check({tag, "_aw_pl"}, pack_pl(m_awid, m_awaddr, m_awlen, m_awburst), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; atx_vld = 1'b0; atx_last = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0;
    m_arready = 1'b1; m_awready = 1'b1;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0; err_clr = 1'b0;

    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_atx_rdy", atx_rdy, 1);

    // Single transaction: valids for exactly one cycle, count 0 -> 1 -> 0.
    @(posedge clk); #1;
    send_atx(5'd1, 32'h1000, 32'h2000, 8'd15, 1'b1, w);
    atx_vld = 1'b0;
    @(negedge clk);
    check("single_arvalid_n1", m_arvalid, 1);
    check("single_awvalid_n1", m_awvalid, 1);
    check("single_outst_1", outst_cnt, 1);
    @(negedge clk);
    check("single_arvalid_n2", m_arvalid, 0);
    check("single_awvalid_n2", m_awvalid, 0);
    @(posedge clk); #1;
    send_b(5'd1, RESP_OKAY, 1'b1);
    @(negedge clk);
    check("single_outst_0", outst_cnt, 0);
    check("single_no_err", tx_err, 0);

    // Skewed handshake: AW stalled 5 cycles, AR completes immediately.
    @(posedge clk); #1 m_awready = 1'b0;
    send_atx(5'd2, 32'h3000, 32'h4000, 8'd7, 1'b1, w);
    atx_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("skew_atx_rdy_low", atx_rdy, 0);
      check("skew_awvalid", m_awvalid, 1);
      check("skew_arvalid", m_arvalid, (i == 0) ? 1 : 0);
    end
    @(posedge clk); #1 m_awready = 1'b1;
    @(negedge clk);
    check("skew_atx_rdy_on_aw_hs", atx_rdy, 1);
    @(negedge clk);
    check("skew_awvalid_done", m_awvalid, 0);
    @(posedge clk); #1;
    send_b(5'd2, RESP_OKAY, 1'b1);

    // Back-to-back accepts, tx_done only on the last B.
    send_atx(5'd3, 32'h5000, 32'h6000, 8'd3, 1'b0, w); check("b2b_wait0", w, 0);
    send_atx(5'd4, 32'h5040, 32'h6040, 8'd3, 1'b0, w); check("b2b_wait1", w, 0);
    send_atx(5'd5, 32'h5080, 32'h6080, 8'd3, 1'b1, w); check("b2b_wait2", w, 0);
    atx_vld = 1'b0;
    @(negedge clk);
    check("b2b_outst_3", outst_cnt, 3);
    @(posedge clk); #1;
    send_b(5'd3, RESP_OKAY, 1'b0);
    send_b(5'd4, RESP_OKAY, 1'b0);
    send_b(5'd5, RESP_OKAY, 1'b1);

    // B with nothing outstanding is not accepted.
    m_bid = 5'd9; m_bresp = RESP_OKAY; m_bvalid = 1'b1;
    @(negedge clk);
    check("empty_bready", m_bready, 0);
    check("empty_outst", outst_cnt, 0);
    @(posedge clk); #1 m_bvalid = 1'b0;

    // Backpressure: 4 outstanding blocks accept; a popping B frees it a cycle later.
    send_atx(5'd8,  32'h7000, 32'h8000, 8'd1, 1'b0, w); check("bp_wait0", w, 0);
    send_atx(5'd9,  32'h7100, 32'h8100, 8'd1, 1'b0, w); check("bp_wait1", w, 0);
    send_atx(5'd10, 32'h7200, 32'h8200, 8'd1, 1'b0, w); check("bp_wait2", w, 0);
    send_atx(5'd11, 32'h7300, 32'h8300, 8'd1, 1'b1, w); check("bp_wait3", w, 0);
    arid = 5'd12; awid = 5'd12; araddr = 32'h7400; awaddr = 32'h8400;
    arlen = 8'd2; awlen = 8'd2; atx_last = 1'b1;
    @(negedge clk);
    check("bp_full_rdy", atx_rdy, 0);
    check("bp_outst_4", outst_cnt, 4);
    @(posedge clk); #1;
    m_bid = 5'd8; m_bresp = RESP_OKAY; m_bvalid = 1'b1;
    @(negedge clk);
    check("bp_bready", m_bready, 1);
    check("bp_same_cycle_rdy", atx_rdy, 0);
    b_exp_q.push_back(1'b0);
    @(posedge clk); #1 m_bvalid = 1'b0;
    @(negedge clk);
    check("bp_next_cycle_rdy", atx_rdy, 1);
    ar_exp_q.push_back(pack_pl(5'd12, 32'h7400, 8'd2, BURST_INCR));
    aw_exp_q.push_back(pack_pl(5'd12, 32'h8400, 8'd2, BURST_INCR));
    @(posedge clk); #1 atx_vld = 1'b0;
    check("bp_outst_refill", outst_cnt, 4);
    send_b(5'd9,  RESP_OKAY, 1'b0);
    send_b(5'd10, RESP_OKAY, 1'b0);
    send_b(5'd11, RESP_OKAY, 1'b1);
    send_b(5'd12, RESP_OKAY, 1'b1);
    check("bp_no_err", tx_err, 0);

    // Error response: sticky until cleared.
    send_atx(5'd13, 32'h9000, 32'hA000, 8'd0, 1'b1, w);
    atx_vld = 1'b0;
    send_b(5'd13, 2'b10, 1'b1);
    @(negedge clk);
    check("err_slverr_set", tx_err, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", tx_err, 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_cleared", tx_err, 0);

    // Wrong bid flags an error.
    send_atx(5'd14, 32'h9100, 32'hA100, 8'd0, 1'b0, w);
    atx_vld = 1'b0;
    send_b(5'd15, RESP_OKAY, 1'b0);
    check("err_bid_set", tx_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_bid_cleared", tx_err, 0);

    // Error and err_clr in the same cycle: set wins.
    send_atx(5'd16, 32'h9200, 32'hA200, 8'd0, 1'b1, w);
    atx_vld = 1'b0;
    err_clr = 1'b1;
    send_b(5'd16, 2'b11, 1'b1);
    err_clr = 1'b0;
    check("err_set_wins", tx_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_final_clear", tx_err, 0);

    // Reset mid-burst: 2 outstanding, AW pending.
    send_atx(5'd20, 32'hB000, 32'hC000, 8'd4, 1'b0, w);
    send_atx(5'd21, 32'hB100, 32'hC100, 8'd4, 1'b0, w);
    atx_vld = 1'b0; m_awready = 1'b0;
    @(negedge clk);
    check("rst_mid_awpend", m_awvalid, 1);
    check("rst_mid_outst", outst_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    ar_exp_q.delete(); aw_exp_q.delete(); b_exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; m_awready = 1'b1;
    @(negedge clk);
    check("rst_mid_atx_rdy", atx_rdy, 1);
    check("rst_mid_outst_after", outst_cnt, 0);

    // Normal operation resumes after reset.
    @(posedge clk); #1;
    send_atx(5'd22, 32'hD000, 32'hE000, 8'd15, 1'b1, w);
    atx_vld = 1'b0;
    send_b(5'd22, RESP_OKAY, 1'b1);
    @(negedge clk);
    check("post_rst_outst", outst_cnt, 0);
    repeat (3) @(negedge clk);
    check("ar_q_drained", ar_exp_q.size(), 0);
    check("aw_q_drained", aw_exp_q.size(), 0);
    check("b_q_drained", b_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
